// File: rtl/sparsity_pkg.sv
// Shared constants, FSM state codes and popcount helper for the sparsity mask streamer.
package sparsity_pkg;

    localparam int WORD_W          = 32;
    localparam int SPARSITY_ADDR_W = 11;
    localparam int DEFAULT_LANES   = 8;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE       = 3'd0;
    localparam state_t S_FETCH_ADDR = 3'd1;
    localparam state_t S_FETCH_DATA = 3'd2;
    localparam state_t S_STREAM     = 3'd3;
    localparam state_t S_DONE       = 3'd4;

    function automatic logic [5:0] popcount(input logic [WORD_W-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < WORD_W; i++) n = n + 6'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/sparsity_mask_streamer_if.sv
// Memory read port and mask stream bundle between the streamer, sparsity_memory and the PE array.
interface sparsity_mask_streamer_if #(
    parameter int LANES  = 8,
    parameter int ADDR_W = 11
);
    import sparsity_pkg::*;

    localparam int PCNT_W = $clog2(LANES) + 1;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [WORD_W-1:0] rd_data;
    logic              mask_valid;
    logic              mask_ready;
    logic [LANES-1:0]  mask;
    logic [PCNT_W-1:0] mask_popcnt;
    logic              mask_last;

    modport master (
        output rd_en, rd_addr,
        input  rd_data,
        output mask_valid, mask, mask_popcnt, mask_last,
        input  mask_ready
    );

    modport slave (
        input  rd_en, rd_addr,
        output rd_data,
        input  mask_valid, mask, mask_popcnt, mask_last,
        output mask_ready
    );

endinterface

// File: rtl/sparsity_word_buffer.sv
// Two-entry word FIFO holding fetched bitmask words until their last chunk is consumed.
module sparsity_word_buffer
    import sparsity_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] push_data,
    output logic [WORD_W-1:0] head,
    output logic              full,
    output logic              empty
);

    logic [1:0][WORD_W-1:0] mem_q, mem_d;
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [1:0]             count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        count_d = count_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);

endmodule

// File: rtl/sparsity_mask_streamer.sv
// Fetches a run of sparsity words, slices them into LANES-bit masks with popcount and
// streams them over valid/ready; bypass mode emits all-ones masks without memory reads.
module sparsity_mask_streamer
    import sparsity_pkg::*;
#(
    parameter int LANES  = DEFAULT_LANES,
    parameter int ADDR_W = SPARSITY_ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              CONF_STR_SPARSITY,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [ADDR_W-1:0]        num_words,
    sparsity_mask_streamer_if.master bus,
    output logic                     busy,
    output logic                     done
);

    localparam int NCHUNK = WORD_W / LANES;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int PCNT_W = $clog2(LANES) + 1;

    state_t              state_q, state_d;
    logic                bypass_q, bypass_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]   fetch_left_q, fetch_left_d;
    logic [ADDR_W-1:0]   stream_left_q, stream_left_d;
    logic [CW-1:0]       chunk_q, chunk_d;

    logic                push, pop, buf_full, buf_empty, buf_full_next;
    logic [WORD_W-1:0]   buf_head;
    logic [NCHUNK-1:0][LANES-1:0] chunks;
    logic                streaming, valid, hs, last_chunk, word_done, final_word, run_end;
    logic [LANES-1:0]    mask_w;

    sparsity_word_buffer u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (bus.rd_data),
        .head      (buf_head),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    assign streaming  = (state_q == S_FETCH_ADDR) || (state_q == S_FETCH_DATA) ||
                        (state_q == S_STREAM);
    assign valid      = streaming && (stream_left_q != '0) && (bypass_q || !buf_empty);
    assign hs         = valid && bus.mask_ready;
    assign last_chunk = (chunk_q == CW'(NCHUNK - 1));
    assign final_word = (stream_left_q == ADDR_W'(1));
    assign word_done  = hs && last_chunk;
    assign run_end    = word_done && final_word;
    assign push       = (state_q == S_FETCH_DATA);
    assign pop        = word_done && !bypass_q;
    // A new read may only start if a slot is still free after this cycle's push/pop.
    assign buf_full_next = (buf_full && !pop) || (!buf_full && !buf_empty && push && !pop);

    assign chunks = bypass_q ? {WORD_W{1'b1}} : buf_head;
    assign mask_w = valid ? chunks[chunk_q] : '0;

    assign bus.rd_en       = (state_q == S_FETCH_ADDR) || (state_q == S_FETCH_DATA);
    assign bus.rd_addr     = rd_addr_q;
    assign bus.mask_valid  = valid;
    assign bus.mask        = mask_w;
    assign bus.mask_popcnt = PCNT_W'(popcount(WORD_W'(mask_w)));
    assign bus.mask_last   = valid && last_chunk && final_word;
    assign busy            = (state_q != S_IDLE);
    assign done            = (state_q == S_DONE);

    always_comb begin
        state_d       = state_q;
        bypass_d      = bypass_q;
        rd_addr_d     = rd_addr_q;
        fetch_left_d  = fetch_left_q;
        stream_left_d = stream_left_q;
        chunk_d       = chunk_q;
        if (hs) chunk_d = last_chunk ? '0 : chunk_q + CW'(1);
        if (word_done) stream_left_d = stream_left_q - ADDR_W'(1);
        case (state_q)
            S_IDLE: if (start) begin
                bypass_d      = (CONF_STR_SPARSITY == '0);
                stream_left_d = num_words;
                fetch_left_d  = (CONF_STR_SPARSITY == '0) ? '0 : num_words;
                chunk_d       = '0;
                // Zero-length runs pass through STREAM so done lands two cycles after start.
                if (num_words == '0 || CONF_STR_SPARSITY == '0) begin
                    state_d = S_STREAM;
                end else begin
                    state_d   = S_FETCH_ADDR;
                    rd_addr_d = base_addr;
                end
            end
            S_FETCH_ADDR: state_d = S_FETCH_DATA;
            S_FETCH_DATA: begin
                fetch_left_d = fetch_left_q - ADDR_W'(1);
                if (fetch_left_q != ADDR_W'(1) && !buf_full_next) begin
                    state_d   = S_FETCH_ADDR;
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (stream_left_q == '0 || run_end) begin
                    state_d = S_DONE;
                end else if (fetch_left_q != '0 && !buf_full_next) begin
                    state_d   = S_FETCH_ADDR;
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            bypass_q      <= 1'b0;
            rd_addr_q     <= '0;
            fetch_left_q  <= '0;
            stream_left_q <= '0;
            chunk_q       <= '0;
        end else begin
            state_q       <= state_d;
            bypass_q      <= bypass_d;
            rd_addr_q     <= rd_addr_d;
            fetch_left_q  <= fetch_left_d;
            stream_left_q <= stream_left_d;
            chunk_q       <= chunk_d;
        end
    end

endmodule

// File: doc/sparsity_mask_streamer.md
# sparsity_mask_streamer

Upstream-facing reader for `sparsity_memory`. On a start pulse it fetches a run of consecutive 32-bit sparsity bitmask words over the memory's `rd_en`/`rd_addr`/`rd_data` port. It slices each word into LANES-bit mask chunks with per-chunk popcount and streams them to the PE-array zero-skip logic over a valid/ready handshake. When sparsity is disabled it generates all-ones masks without touching the memory.

## Interface
Parameters:
- LANES, 8, mask bits per output chunk; must be one of 1, 2, 4, 8, 16, 32.
- ADDR_W, 11, sparsity memory word address width (bit 10 selects bank).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- CONF_STR_SPARSITY  in  16  sparsity config; 0 = bypass (all-ones masks, no reads); sampled on accepted start.
- start  in  1  one-cycle request; ignored while busy.
- base_addr  in  ADDR_W  first word address; sampled on accepted start.
- num_words  in  ADDR_W  words to stream; sampled on accepted start.
- rd_en  out  1  read enable to sparsity_memory.
- rd_addr  out  ADDR_W  read address to sparsity_memory.
- rd_data  in  32  read data from sparsity_memory.
- mask_valid  out  1  chunk available.
- mask_ready  in  1  consumer accepts chunk.
- mask  out  LANES  mask chunk; bit=1 means nonzero operand.
- mask_popcnt  out  $clog2(LANES)+1  count of ones in mask.
- mask_last  out  1  final chunk of the run.
- busy  out  1  run in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, FETCH_ADDR, FETCH_DATA, STREAM, DONE.
- IDLE: start accepted → latch base, count, mode, busy=1.
  - num_words=0 → DONE.
  - Bypass → STREAM with all-ones words.
  - Otherwise → FETCH_ADDR.
- FETCH_ADDR: drive rd_en=1 and rd_addr=current address for one cycle.
- FETCH_DATA: hold rd_addr and rd_en. Capture rd_data at end of this cycle into the 2-entry word buffer, increment the address modulo 2^ADDR_W, decrement words-to-fetch.
- Prefetch: a new FETCH_ADDR begins whenever the buffer has a free entry and words remain. Fetching overlaps STREAM.
- STREAM: the head word is emitted as 32/LANES chunks, LSB first: chunk k = word[k*LANES +: LANES]. The head word is popped after its last chunk handshakes.
- Address progression: address increments by 1 per word and wraps 2047→0, crossing banks freely.
- Run end: mask_last=1 only on the final chunk of the final word. Its handshake → DONE.
- DONE: done=1 for one cycle, busy=0 next cycle, → IDLE.
- Idle outputs: rd_en=0. rd_addr keeps its last value, so a restart at the same address still returns valid held data.
- Constraint: sparsity memory must not be written at an address inside an active run.

## Timing
- Reset values: all outputs 0. Async reset mid-run clears state, buffer, and outputs immediately; no done pulse.
- Memory mode:
  - start at cycle 0 → rd_en=1, rd_addr=base at cycle 1.
  - Data captured end of cycle 2.
  - mask_valid=1 at cycle 3.
- Bypass mode: mask_valid=1 at cycle 1.
- Throughput: one chunk per cycle while mask_ready=1 and LANES≤16; no bubbles between words. LANES=32 sustains one chunk every 2 cycles.
- Handshake:
  - mask, mask_popcnt, mask_last stay stable while mask_valid=1 and mask_ready=0.
  - mask_valid never drops without a handshake.
  - mask_ready may be high before mask_valid.
- Backpressure: with the buffer full, no new read is issued; rd_addr holds.
- done timing: asserts the cycle after the last-chunk handshake. start on that same cycle is ignored. start is accepted from the cycle after done.
- num_words=0: done at cycle 2, no rd_en, no mask_valid.

## Structure
- Package sparsity_pkg:
  - WORD_W=32, SPARSITY_ADDR_W=11, default LANES.
  - State enum.
  - Function popcount(LANES).
- Sub-module sparsity_word_buffer: 2-entry FIFO of 32-bit words with push, pop, full, empty, and head output. The top holds the FSM, address counter, and chunk slicer.

## Test plan
- Basic run: memory words 0x0000_00FF at 5 and 0x8000_0001 at 6; start base=5, num_words=2, LANES=8, mask_ready=1.
  - Chunks in order: FF, 00, 00, 00, 01, 00, 00, 80.
  - popcnt: 8, 0, 0, 0, 1, 0, 0, 1.
  - mask_last on the 8th chunk; done one cycle later.
  - First mask_valid at cycle 3 after start.
- Bank wrap: base=2046, num_words=3 → reads 2046, 2047, 0; 12 chunks; rd_addr sequence exact.
- Backpressure: random mask_ready at 30% duty over 16 words → chunk sequence identical to the ready=1 run; outputs stable while stalled; never more than 2 words buffered.
- Bypass: CONF_STR_SPARSITY=0, num_words=2 → 8 chunks of 0xFF, popcnt 8; rd_en stays 0 throughout; first mask_valid at cycle 1.
- Edge cases:
  - num_words=0 → done at cycle 2, no mask_valid.
  - start while busy → ignored.
  - reset mid-run (cycle 5) → all outputs 0 immediately; a new start runs cleanly.
